// File: rtl/gb_uc_pkg.sv
// gb_uc_pkg: shared encodings for the control-unit microcode sequencers.
package gb_uc_pkg;
  localparam logic [1:0] MODE_ADD_SP = 2'b01;
  localparam logic [1:0] MODE_LD_HL = 2'b10;
  localparam int unsigned PC_REG = 5;
  localparam int unsigned SP_REG = 4;
  localparam int unsigned HL_REG = 3;
  localparam int unsigned Z_REG = 0;
  localparam logic [3:0] M1 = 4'b0001;
  localparam logic [3:0] M2 = 4'b0010;
  localparam logic [3:0] M3 = 4'b0100;
  localparam logic [3:0] M4 = 4'b1000;
endpackage

// File: rtl/uc_step_counter.sv
// uc_step_counter: one-hot T-step / M-cycle counter with start, clear and stall.
module uc_step_counter
  import gb_uc_pkg::*;
#(
  parameter int unsigned STEPS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             stall_i,
  output logic [STEPS-1:0] step_o,
  output logic [3:0]       cycle_o
);
  logic [STEPS-1:0] step_q, step_d;
  logic [3:0] cycle_q, cycle_d;
  // An idle (all-zero) step vector rotates to itself, so no separate run flag is needed.
  always_comb begin
    step_d = start_i ? {{(STEPS-1){1'b0}}, 1'b1} :
             clear_i ? '0 : {step_q[STEPS-2:0], step_q[STEPS-1]};
    cycle_d = start_i ? M1 :
              clear_i ? 4'b0000 :
              step_q[STEPS-1] ? {cycle_q[2:0], 1'b0} : cycle_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      step_q <= '0;
      cycle_q <= '0;
    end else if (!stall_i) begin
      step_q <= step_d;
      cycle_q <= cycle_d;
    end
  assign step_o = step_q;
  assign cycle_o = cycle_q;
endmodule

// File: rtl/sp_rel_add_sequencer.sv
// sp_rel_add_sequencer: microcode engine for ADD SP,s8 and LD HL,SP+s8.
module sp_rel_add_sequencer
  import gb_uc_pkg::*;
#(
  parameter int unsigned STEPS = 4,
  parameter int unsigned R8_W = 8,
  parameter int unsigned R16_W = 6,
  parameter int unsigned PC_IDX = PC_REG,
  parameter int unsigned SP_IDX = SP_REG,
  parameter int unsigned HL_IDX = HL_REG,
  parameter int unsigned Z_IDX = Z_REG
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  input  logic [1:0]       i_P,
  input  logic             i_Stall,
  input  logic [15:0]      i_SP,
  input  logic [7:0]       i_Bus_Data,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [STEPS-1:0] o_Step,
  output logic [3:0]       o_Cycle,
  output logic             o_IR_Fetch,
  output logic             o_Bus_In,
  output logic             o_Address_Out,
  output logic [R8_W-1:0]  o_Read8,
  output logic [R8_W-1:0]  o_Write8,
  output logic [R16_W-1:0] o_Read16,
  output logic [R16_W-1:0] o_Write16,
  output logic [1:0]       o_Increment16,
  output logic [1:0]       o_Add_r8_Control,
  output logic [15:0]      o_Result,
  output logic [3:0]       o_Flags
);
  typedef enum logic [1:0] {IDLE, RUN, FETCH} state_e;
  state_e state_q;
  logic add_q;
  logic [7:0] e_q;
  logic [15:0] result_q;
  logic [3:0] flags_q;
  logic [STEPS-1:0] step;
  logic [3:0] cycle;
  logic legal, accept, clear, last_run, m1s0, m1s1, m2s0, m2s1, m2s2, h;
  logic [8:0] lo9;
  logic [7:0] hi;
  assign legal = i_P == MODE_ADD_SP || i_P == MODE_LD_HL;
  assign accept = i_Start && legal && !i_Stall && (state_q == IDLE || state_q == FETCH);
  assign clear = state_q == FETCH && !accept;
  assign last_run = state_q == RUN && step[STEPS-1] && cycle == (add_q ? M3 : M2);
  assign m1s0 = cycle == M1 && step[0];
  assign m1s1 = cycle == M1 && step[1];
  assign m2s0 = cycle == M2 && step[0];
  assign m2s1 = cycle == M2 && step[1];
  assign m2s2 = cycle == M2 && step[2];
  // Split add: the low byte's carry-out is C, and bit 4 of the low sum recovers the nibble carry H.
  assign lo9 = {1'b0, i_SP[7:0]} + {1'b0, e_q};
  assign hi = i_SP[15:8] + {8{e_q[7]}} + {7'd0, lo9[8]};
  assign h = i_SP[4] ^ e_q[4] ^ lo9[4];
  uc_step_counter #(.STEPS(STEPS)) u_cnt (
    .clk_i(i_Clk),
    .rst_ni(i_Reset_n),
    .start_i(accept),
    .clear_i(clear),
    .stall_i(i_Stall),
    .step_o(step),
    .cycle_o(cycle)
  );
  always_ff @(posedge i_Clk or negedge i_Reset_n)
    if (!i_Reset_n) begin
      state_q <= IDLE;
      add_q <= 1'b0;
      e_q <= '0;
      result_q <= '0;
      flags_q <= '0;
    end else if (!i_Stall) begin
      state_q <= accept ? RUN : last_run ? FETCH : state_q == FETCH ? IDLE : state_q;
      if (accept) add_q <= i_P == MODE_ADD_SP;
      if (m2s0) e_q <= i_Bus_Data;
      if (m2s2) begin
        result_q <= {hi, lo9[7:0]};
        flags_q <= {2'b00, h, lo9[8]};
      end
    end
  assign o_Busy = state_q != IDLE;
  assign o_Done = state_q == FETCH;
  assign o_IR_Fetch = state_q == FETCH;
  assign o_Step = step;
  assign o_Cycle = cycle;
  assign o_Address_Out = m1s0;
  assign o_Bus_In = m2s0;
  assign o_Read8 = R8_W'(m2s1) << Z_IDX;
  assign o_Write8 = R8_W'(m2s0) << Z_IDX;
  assign o_Read16 = (R16_W'(m1s0) << PC_IDX) | (R16_W'(m2s1) << SP_IDX);
  assign o_Write16 = (R16_W'(m1s1) << PC_IDX) | (R16_W'(m2s2 && add_q) << SP_IDX) |
                     (R16_W'(m2s2 && !add_q) << HL_IDX);
  assign o_Increment16 = {1'b0, m1s1};
  assign o_Add_r8_Control = {m2s2, m2s2};
  assign o_Result = result_q;
  assign o_Flags = flags_q;
endmodule

// File: tb/tb_sp_rel_add_sequencer.sv
// tb_sp_rel_add_sequencer: directed scenarios plus random traffic against a position-count model.
module tb_sp_rel_add_sequencer;
  localparam int STEPS = 4;
  localparam int PC = 5, SP = 4, HL = 3, Z = 0;
  logic clk = 0, rst_n = 0, start = 0, stall = 0;
  logic [1:0] p = 0;
  logic [15:0] sp = 0;
  logic [7:0] bus = 0;
  logic o_Busy, o_Done, o_IR_Fetch, o_Bus_In, o_Address_Out;
  logic [STEPS-1:0] o_Step;
  logic [3:0] o_Cycle, o_Flags;
  logic [7:0] o_Read8, o_Write8;
  logic [5:0] o_Read16, o_Write16;
  logic [1:0] o_Increment16, o_Add_r8_Control;
  logic [15:0] o_Result;
  logic [64:0] allout;
  int passed = 0, total = 0;

  sp_rel_add_sequencer #(.STEPS(STEPS)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start), .i_P(p), .i_Stall(stall),
    .i_SP(sp), .i_Bus_Data(bus), .o_Busy(o_Busy), .o_Done(o_Done), .o_Step(o_Step),
    .o_Cycle(o_Cycle), .o_IR_Fetch(o_IR_Fetch), .o_Bus_In(o_Bus_In),
    .o_Address_Out(o_Address_Out), .o_Read8(o_Read8), .o_Write8(o_Write8),
    .o_Read16(o_Read16), .o_Write16(o_Write16), .o_Increment16(o_Increment16),
    .o_Add_r8_Control(o_Add_r8_Control), .o_Result(o_Result), .o_Flags(o_Flags)
  );

  always #5 clk = ~clk;
  assign allout = {o_Busy, o_Done, o_Step, o_Cycle, o_IR_Fetch, o_Bus_In, o_Address_Out, o_Read8,
                   o_Write8, o_Read16, o_Write16, o_Increment16, o_Add_r8_Control, o_Result, o_Flags};

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  function automatic int fin(input bit add);
    return add ? 3 * STEPS : 2 * STEPS;
  endfunction

  // Model: an instruction is just a count t of un-stalled clocks since accept.
  bit act = 0, madd = 0;
  int t = 0;
  logic [7:0] me = 0;
  logic [15:0] mres = 0;
  logic [3:0] mflg = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act <= 0; t <= 0; madd <= 0; me <= 0; mres <= 0; mflg <= 0;
    end else if (!stall) begin
      if (act && t == STEPS) me <= bus;
      if (act && t == STEPS + 2) begin
        mres <= 16'(int'(sp) + int'($signed(me)));
        mflg <= {2'b00, (int'(sp[3:0]) + int'(me[3:0])) > 15, (int'(sp[7:0]) + int'(me)) > 255};
      end
      if (start && (p == 2'b01 || p == 2'b10) && (!act || t == fin(madd))) begin
        act <= 1; t <= 0; madd <= p == 2'b01;
      end else if (act && t == fin(madd)) act <= 0;
      else if (act) t <= t + 1;
    end

  always @(negedge clk) begin : cmp
    int s, m;
    logic fe, a00, a01, a10, a11, a12;
    logic [STEPS-1:0] es;
    logic [3:0] ec;
    logic [7:0] r8, w8;
    logic [5:0] r16, w16;
    s = t % STEPS;
    m = t / STEPS;
    fe = act && t == fin(madd);
    es = act ? STEPS'(1 << s) : '0;
    ec = act ? 4'(1 << m) : 4'b0000;
    a00 = act && m == 0 && s == 0;
    a01 = act && m == 0 && s == 1;
    a10 = act && m == 1 && s == 0;
    a11 = act && m == 1 && s == 1;
    a12 = act && m == 1 && s == 2;
    r8 = 0; w8 = 0; r16 = 0; w16 = 0;
    r8[Z] = a11;
    w8[Z] = a10;
    r16[PC] = a00;
    r16[SP] = a11;
    w16[PC] = a01;
    w16[SP] = a12 && madd;
    w16[HL] = a12 && !madd;
    chk("seq", {o_Busy, o_Done, o_Step, o_Cycle}, {act, fe, es, ec});
    chk("strobes", {o_IR_Fetch, o_Bus_In, o_Address_Out, o_Read8, o_Write8, o_Read16, o_Write16,
                    o_Increment16, o_Add_r8_Control},
        {fe, a10, a00, r8, w8, r16, w16, 1'b0, a01, a12, a12});
    chk("result", {o_Result, o_Flags}, {mres, mflg});
  end

  task automatic run(input logic [1:0] pm, input logic [15:0] spv, input logic [7:0] bv,
                     input int st_at, input int st_len,
                     output int done_at, output int busin, output int wsp_at, output int whl_at);
    @(negedge clk);
    start = 1; p = pm; sp = spv; bus = bv;
    done_at = 0; busin = 0; wsp_at = 0; whl_at = 0;
    for (int i = 1; i <= 60 && done_at == 0; i++) begin
      @(negedge clk);
      start = 0;
      if (o_Bus_In) busin++;
      if (o_Write16[SP]) wsp_at = i;
      if (o_Write16[HL]) whl_at = i;
      if (o_Done) done_at = i;
      stall = i >= st_at && i < st_at + st_len;
    end
    stall = 0;
  endtask

  initial begin
    int d, b, ws, wh, cnt;
    repeat (3) @(negedge clk);
    chk("reset_zero", allout, 0);
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", o_Busy, 0);
    end
    run(2'b01, 16'hFFF8, 8'h08, 0, 0, d, b, ws, wh);
    chk("add_done_at", d, 13);
    chk("add_wsp_at", ws, 7);
    chk("add_whl", wh, 0);
    chk("add_res", {o_Result, o_Flags}, {16'h0000, 4'b0011});
    run(2'b10, 16'h0005, 8'hFE, 0, 0, d, b, ws, wh);
    chk("ld_done_at", d, 9);
    chk("ld_whl_at", wh, 7);
    chk("ld_wsp", ws, 0);
    chk("ld_res", {o_Result, o_Flags}, {16'h0003, 4'b0011});
    run(2'b01, 16'h1000, 8'h80, 5, 3, d, b, ws, wh);
    chk("stall_busin", b, 4);
    chk("stall_done_at", d, 16);
    chk("stall_res", {o_Result, o_Flags}, {16'h0F80, 4'b0000});
    @(negedge clk);
    start = 1; p = 2'b01; sp = 16'h1234; bus = 8'h01;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!o_Done && cnt < 40);
    chk("b2b_first_done", cnt, 13);
    p = 2'b10;
    @(negedge clk);
    start = 0;
    chk("b2b_restart", {o_Busy, o_Done, o_Step, o_Cycle}, {2'b10, 4'b0001, 4'b0001});
    cnt = 1;
    while (!o_Done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_second_done", cnt, 9);
    chk("b2b_res", {o_Result, o_Flags}, {16'h1235, 4'b0000});
    @(negedge clk);
    start = 1; p = 2'b11;
    @(negedge clk);
    p = 2'b00;
    @(negedge clk);
    start = 0;
    chk("illegal_idle", o_Busy, 0);
    @(negedge clk);
    start = 1; p = 2'b01; sp = 16'h0100; bus = 8'h10;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 0;
    end
    chk("m2s1_rd_sp", o_Read16[SP], 1);
    #1 rst_n = 0;
    #1 chk("async_reset", allout, 0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_done", allout, 0);
    end
    rst_n = 1;
    run(2'b01, 16'h0100, 8'h10, 0, 0, d, b, ws, wh);
    chk("post_reset_done_at", d, 13);
    chk("post_reset_res", {o_Result, o_Flags}, {16'h0110, 4'b0000});
    repeat (800) begin
      @(negedge clk);
      start = $urandom_range(0, 99) < 30;
      p = 2'($urandom_range(0, 3));
      stall = $urandom_range(0, 99) < 20;
      sp = 16'($urandom);
      bus = 8'($urandom);
    end
    start = 0; stall = 0;
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
